// File: rtl/chrisruk_matrix_pixel_source.sv
// Glyph-ROM pixel generator for an 8x8 serpentine APA102 matrix.
// Streams one 32-bit LED word per LED over valid/ready and cycles glyphs every N frames.
module chrisruk_matrix_pixel_source #(
  parameter int          FRAMES_PER_GLYPH = 16,
  parameter int          NUM_GLYPHS       = 4,
  parameter logic [31:0] FG_WORD          = 32'hF00F0000,
  parameter logic [31:0] BG_WORD          = 32'hF0000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [31:0] pix_data,
  output logic        pix_first,
  output logic        pix_last,
  output logic [1:0]  glyph_idx,
  output logic        frame_done
);

  localparam int                FCNT_W     = $clog2(FRAMES_PER_GLYPH + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FRAMES_PER_GLYPH - 1);
  localparam logic [1:0]        GLYPH_LAST = 2'(NUM_GLYPHS - 1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [5:0]        led_cnt, led_nxt;
  logic [FCNT_W-1:0] frame_cnt, frame_nxt;
  logic [1:0]        glyph_nxt;
  logic              xfer;

  function automatic logic [63:0] glyph_rom(input logic [1:0] g);
    case (g)
      2'd0:    glyph_rom = 64'h0000780C7CCC7600;
      2'd1:    glyph_rom = 64'h0706063E66663B00;
      2'd2:    glyph_rom = 64'h00001E3303331E00;
      default: glyph_rom = 64'h3830303E33336E00;
    endcase
  endfunction

  // Even rows run right-to-left on the panel, so their column index is mirrored.
  function automatic logic [31:0] led_word(input logic [1:0] g, input logic [5:0] p);
    logic [5:0]  k;
    logic [63:0] bits;
    k    = p[3] ? p : {p[5:3], ~p[2:0]};
    bits = glyph_rom(g);
    return bits[~k] ? FG_WORD : BG_WORD;
  endfunction

  assign pix_valid  = (state == EMIT);
  assign frame_done = (state == DONE);
  assign xfer       = pix_valid & pix_ready;

  always_comb begin
    state_nxt = state;
    led_nxt   = led_cnt;
    frame_nxt = frame_cnt;
    glyph_nxt = glyph_idx;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = EMIT;
          led_nxt   = 6'd0;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (led_cnt == 6'd63) state_nxt = DONE;
          else                  led_nxt   = led_cnt + 6'd1;
        end
      end
      DONE: begin
        led_nxt = 6'd0;
        if (frame_cnt == FCNT_LAST) begin
          frame_nxt = '0;
          glyph_nxt = (glyph_idx == GLYPH_LAST) ? 2'd0 : glyph_idx + 2'd1;
        end else begin
          frame_nxt = frame_cnt + FCNT_W'(1);
        end
        state_nxt = enable ? EMIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      led_cnt   <= 6'd0;
      frame_cnt <= '0;
      glyph_idx <= 2'd0;
    end else begin
      state     <= state_nxt;
      led_cnt   <= led_nxt;
      frame_cnt <= frame_nxt;
      glyph_idx <= glyph_nxt;
    end
  end

  // Output word is looked up from the next LED/glyph so it is ready the cycle EMIT is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_data  <= '0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
    end else if (state_nxt == EMIT) begin
      pix_data  <= led_word(glyph_nxt, led_nxt);
      pix_first <= (led_nxt == 6'd0);
      pix_last  <= (led_nxt == 6'd63);
    end else begin
      pix_data  <= '0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chrisruk_matrix_pixel_source.sv
// Bench for chrisruk_matrix_pixel_source: two instances (16 and 2 frames per glyph)
// share stimulus and are compared against an arithmetic ROM/serpentine model.
module tb_chrisruk_matrix_pixel_source;

  localparam logic [31:0] FG = 32'hF00F0000;
  localparam logic [31:0] BG = 32'hF0000000;
  localparam logic [63:0] ROM_TB [4] = '{64'h0000780C7CCC7600, 64'h0706063E66663B00,
                                         64'h00001E3303331E00, 64'h3830303E33336E00};

  logic        clk = 1'b0;
  logic        reset, enable, pix_ready;
  logic        v1, f1, l1, d1, v2, f2, l2, d2;
  logic [31:0] data1, data2;
  logic [1:0]  g1, g2;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  chrisruk_matrix_pixel_source u1 (
    .clk(clk), .reset(reset), .enable(enable), .pix_ready(pix_ready),
    .pix_valid(v1), .pix_data(data1), .pix_first(f1), .pix_last(l1),
    .glyph_idx(g1), .frame_done(d1)
  );

  chrisruk_matrix_pixel_source #(.FRAMES_PER_GLYPH(2)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .pix_ready(pix_ready),
    .pix_valid(v2), .pix_data(data2), .pix_first(f2), .pix_last(l2),
    .glyph_idx(g2), .frame_done(d2)
  );

  function automatic logic [31:0] exp_word(input int g, input int p);
    logic [63:0] bits;
    int r, c, k;
    bits = ROM_TB[g];
    r = p / 8;
    c = p % 8;
    k = (r % 2 == 0) ? r * 8 + 7 - c : r * 8 + c;
    return bits[63 - k] ? FG : BG;
  endfunction

  function automatic int exp_glyph(input int frames, input int fpg);
    return (frames / fpg) % 4;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({v1, f1, l1, d1, g1, data1} !== 38'd0)
      $display("FAIL reset_state got v=%b f=%b l=%b fd=%b g=%0d d=%h, need all zero", v1, f1, l1, d1, g1, data1);
    else pass_cnt++;
    total_cnt++;
    if ({v2, f2, l2, d2, g2, data2} !== 38'd0)
      $display("FAIL reset_state_u2 got v=%b g=%0d d=%h, need all zero", v2, g2, data2);
    else pass_cnt++;
    reset = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({v1, d1} !== 2'b00) $display("FAIL idle_no_enable got v=%b fd=%b, need 0 0", v1, d1);
    else pass_cnt++;
  endtask

  task automatic test_first_frame();
    do_reset();
    @(negedge clk);
    enable = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({v1, f1, l1, data1} !== {1'b1, i == 0, i == 63, exp_word(0, i)})
        $display("FAIL t1_led%0d got v=%b f=%b l=%b d=%h, need v=1 f=%b l=%b d=%h",
                 i, v1, f1, l1, data1, i == 0, i == 63, exp_word(0, i));
      else pass_cnt++;
      if (i == 16 || i == 24) begin
        total_cnt++;
        if (data1 !== BG) $display("FAIL t1_bg_led%0d got %h need %h", i, data1, BG);
        else pass_cnt++;
      end
      if (i == 19 || i == 28) begin
        total_cnt++;
        if (data1 !== FG) $display("FAIL t1_fg_led%0d got %h need %h", i, data1, FG);
        else pass_cnt++;
      end
      if (i == 63) enable = 1'b0;
    end
    @(negedge clk);
    total_cnt++;
    if ({v1, d1, g1} !== 4'b0100) $display("FAIL t1_done got v=%b fd=%b g=%0d, need 0 1 0", v1, d1, g1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({v1, d1} !== 2'b00) $display("FAIL t1_idle got v=%b fd=%b, need 0 0", v1, d1);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int idx, stall, pulses, seen10;
    idx = 0; stall = 0; pulses = 0; seen10 = 0;
    do_reset();
    @(negedge clk);
    enable = 1'b1; pix_ready = 1'b1;
    for (int cyc = 0; cyc < 90; cyc++) begin
      @(negedge clk);
      if (d1) pulses++;
      if (idx == 1) enable = 1'b0;
      if (v1) begin
        total_cnt++;
        if ({f1, l1, data1} !== {idx == 0, idx == 63, exp_word(0, idx)})
          $display("FAIL t2_led%0d got f=%b l=%b d=%h, need f=%b l=%b d=%h",
                   idx, f1, l1, data1, idx == 0, idx == 63, exp_word(0, idx));
        else pass_cnt++;
        if (idx == 10) seen10++;
        if (idx == 10 && stall < 5) begin
          pix_ready = 1'b0;
          stall++;
        end else begin
          pix_ready = 1'b1;
          idx++;
        end
      end else if (stall > 0 && idx == 10) begin
        total_cnt++;
        $display("FAIL t2_valid_dropped got v=0 need v=1 while stalled");
      end
    end
    total_cnt++;
    if (seen10 != 6) $display("FAIL t2_led10_presented got %0d cycles need 6", seen10);
    else pass_cnt++;
    total_cnt++;
    if (idx != 64 || pulses != 1) $display("FAIL t2_frame got words=%0d pulses=%0d need 64 1", idx, pulses);
    else pass_cnt++;
  endtask

  task automatic test_glyph_advance();
    int w, pulses, last_cyc, need_cyc;
    logic after;
    w = 0; pulses = 0; last_cyc = 0; after = 1'b0;
    do_reset();
    @(negedge clk);
    enable = 1'b1; pix_ready = 1'b1;
    for (int cyc = 1; cyc < 700; cyc++) begin
      @(negedge clk);
      if (after) begin
        after = 1'b0;
        total_cnt++;
        if ({g2, g1} !== {2'(exp_glyph(pulses, 2)), 2'(exp_glyph(pulses, 16))})
          $display("FAIL t3_glyph_after_%0d got u2=%0d u1=%0d need u2=%0d u1=%0d",
                   pulses, g2, g1, exp_glyph(pulses, 2), exp_glyph(pulses, 16));
        else pass_cnt++;
        if (pulses == 8) break;
      end
      if (v2) begin
        total_cnt++;
        if (data2 !== exp_word(exp_glyph(w / 64, 2), w % 64))
          $display("FAIL t3_word%0d got %h need %h", w, data2, exp_word(exp_glyph(w / 64, 2), w % 64));
        else pass_cnt++;
        w++;
      end
      if (d2) begin
        pulses++;
        after = 1'b1;
        need_cyc = (pulses == 1) ? 65 : last_cyc + 65;
        total_cnt++;
        if (cyc != need_cyc || g2 !== 2'(exp_glyph(pulses - 1, 2)))
          $display("FAIL t3_pulse%0d got cycle=%0d g=%0d need cycle=%0d g=%0d",
                   pulses, cyc, g2, need_cyc, exp_glyph(pulses - 1, 2));
        else pass_cnt++;
        last_cyc = cyc;
      end
    end
    total_cnt++;
    if (pulses != 8) $display("FAIL t3_timeout got %0d pulses need 8", pulses);
    else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    int w, pulses;
    w = 0; pulses = 0;
    do_reset();
    @(negedge clk);
    enable = 1'b1; pix_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (d1) pulses++;
      if (v1) begin
        total_cnt++;
        if (data1 !== exp_word(0, w % 64)) $display("FAIL t4_word%0d got %h need %h", w, data1, exp_word(0, w % 64));
        else pass_cnt++;
        if (w == 20) enable = 1'b0;
        w++;
      end
    end
    total_cnt++;
    if (w != 64 || pulses != 1 || v1 !== 1'b0)
      $display("FAIL t4_finish got words=%0d pulses=%0d v=%b need 64 1 0", w, pulses, v1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int w;
    logic found;
    w = 0; found = 1'b0;
    do_reset();
    @(negedge clk);
    enable = 1'b1; pix_ready = 1'b1;
    for (int cyc = 0; cyc < 2300; cyc++) begin
      @(negedge clk);
      if (v1 && w == 32 * 64 + 30) begin
        found = 1'b1;
        break;
      end
      if (v1) w++;
    end
    total_cnt++;
    if (!found || g1 !== 2'd2 || data1 !== exp_word(2, 30))
      $display("FAIL t5_reach_led30 got found=%b g=%0d d=%h need 1 2 %h", found, g1, data1, exp_word(2, 30));
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({v1, f1, l1, d1, g1} !== 6'd0) $display("FAIL t5_async_clear got v=%b g=%0d need 0 0", v1, g1);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({v1, f1, g1, data1} !== {1'b1, i == 0, 2'd0, exp_word(0, i)})
        $display("FAIL t5_led%0d got v=%b f=%b g=%0d d=%h need v=1 f=%b g=0 d=%h",
                 i, v1, f1, g1, data1, i == 0, exp_word(0, i));
      else pass_cnt++;
      if (i == 63) enable = 1'b0;
    end
  endtask

  task automatic test_random_ready();
    int w, pulses;
    w = 0; pulses = 0;
    do_reset();
    @(negedge clk);
    enable = 1'b1; pix_ready = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (d1) begin
        pulses++;
        total_cnt++;
        if (w != pulses * 64) $display("FAIL t6_pulse%0d got words=%0d need %0d", pulses, w, pulses * 64);
        else pass_cnt++;
        if (pulses == 3) break;
      end
      if (v1) begin
        total_cnt++;
        if ({f1, l1, data1, data2} !== {w % 64 == 0, w % 64 == 63, exp_word(0, w % 64),
                                        exp_word(exp_glyph(w / 64, 2), w % 64)})
          $display("FAIL t6_word%0d got f=%b l=%b d1=%h d2=%h need d1=%h d2=%h", w, f1, l1, data1, data2,
                   exp_word(0, w % 64), exp_word(exp_glyph(w / 64, 2), w % 64));
        else pass_cnt++;
      end
      pix_ready = 1'($urandom_range(0, 1));
      if (v1 && pix_ready) w++;
    end
    total_cnt++;
    if (pulses != 3) $display("FAIL t6_timeout got %0d pulses need 3", pulses);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    test_reset();
    test_first_frame();
    test_stall();
    test_glyph_advance();
    test_enable_drop();
    test_reset_mid_frame();
    test_random_ready();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
